// File: rtl/dmem_lsu.sv
// RV64I data memory with load/store unit: sized/extended loads, byte-merge stores,
// error flagging, fixed LAT response pipeline, post-reset zero sweep. Optional DMEM_PERF_EN adds perf counters.
module dmem_lsu #(
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        init_busy
`ifdef DMEM_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errs
`endif
);

  localparam int AW = $clog2(DEPTH);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic          state;
  logic [AW-1:0] init_cnt;
  logic          accept;

  // Sweep counter walks 0..DEPTH-1, one word per cycle, then hands over to RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else if (state == ST_INIT) begin
      // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
      init_cnt <= init_cnt + AW'(1);
      if (init_cnt == AW'(DEPTH - 1)) state <= ST_RUN;
    end
  end

  assign req_ready = (state == ST_RUN);
  assign init_busy = (state == ST_INIT);
  assign accept    = req_valid && req_ready;

  // Request decode
  logic [2:0]    lane;
  logic [AW-1:0] widx;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic [7:0]    size_mask;
  logic [7:0]    be;
  logic [63:0]   wdata_sh;

  assign lane         = req_addr[2:0];
  assign widx         = req_addr[AW+2:3];
  assign out_of_range = |req_addr[63:AW+3];
  assign req_err      = misaligned || out_of_range;
  assign be           = size_mask << lane;
  assign wdata_sh     = req_wdata << {lane, 3'b000};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (req_size)
      2'd0: begin misaligned = 1'b0;               size_mask = 8'h01; end
      2'd1: begin misaligned = req_addr[0];        size_mask = 8'h03; end
      2'd2: begin misaligned = |req_addr[1:0];     size_mask = 8'h0F; end
      default: begin misaligned = |req_addr[2:0];  size_mask = 8'hFF; end
    endcase
  end

  // Single byte-enabled write port shared by the sweep and stores.
  logic [63:0]   mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [7:0]    wr_be;
  logic [63:0]   wr_data;

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = widx;
    wr_be   = be;
    wr_data = wdata_sh;
    if (state == ST_INIT) begin
      wr_en   = 1'b1;
      wr_idx  = init_cnt;
      wr_be   = 8'hFF;
      wr_data = '0;
    end else if (accept && req_we && !req_err) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: the array has no reset branch; the post-reset sweep clears it, keeping it mappable to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 8; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Load path: read before the edge, so a store on the previous edge is already visible.
  logic [63:0] rd_sh;
  logic [63:0] ld_data;
  logic [63:0] rsp_data_in;

  assign rd_sh = mem[widx] >> {lane, 3'b000};

  always_comb begin
    ld_data = rd_sh;
    case (req_size)
      2'd0: ld_data = req_unsigned ? {56'd0, rd_sh[7:0]}  : {{56{rd_sh[7]}},  rd_sh[7:0]};
      2'd1: ld_data = req_unsigned ? {48'd0, rd_sh[15:0]} : {{48{rd_sh[15]}}, rd_sh[15:0]};
      2'd2: ld_data = req_unsigned ? {32'd0, rd_sh[31:0]} : {{32{rd_sh[31]}}, rd_sh[31:0]};
      default: ld_data = rd_sh;
    endcase
  end

  assign rsp_data_in = (accept && !req_we && !req_err) ? ld_data : 64'd0;

  // Response shift register; stage LAT-1 drives the outputs.
  logic [LAT-1:0]       pipe_v;
  logic [LAT-1:0]       pipe_e;
  logic [LAT-1:0][63:0] pipe_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_e <= '0;
      pipe_d <= '0;
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept && req_err;
      pipe_d[0] <= rsp_data_in;
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign rsp_valid = pipe_v[LAT-1];
  assign rsp_err   = pipe_e[LAT-1];
  assign rsp_rdata = pipe_d[LAT-1];

`ifdef DMEM_PERF_EN
  // Saturating counters; an error request counts only as an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_loads  <= '0;
      perf_stores <= '0;
      perf_errs   <= '0;
    end else if (accept) begin
      if (req_err) begin
        if (~&perf_errs) perf_errs <= perf_errs + 32'd1;
      end else if (req_we) begin
        if (~&perf_stores) perf_stores <= perf_stores + 32'd1;
      end else begin
        if (~&perf_loads) perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule
